row_mem_scatter_ctrl: RTL and testbench

//  Generic scatter engine between a global-buffer read stream and the PE-array row memories.
//  - Accepts a linear valid/ready stream of activation or weight bytes.
//  - Writes each byte into one of NUM_ROW_MEM row memories at an in-row address.
//  - Placement is set by a runtime row length, interleave group, pass count and pass step.
//  - Instantiated once for the IA path and once for the weight path. Replaces fixed K/OC address math.

---
 rtl/row_mem_scatter_ctrl_if.sv | 11 +
 rtl/row_mem_scatter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_row_mem_scatter_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_mem_scatter_ctrl_if.sv
// Valid/ready byte stream from the global-buffer read port into the row-memory scatter engine.
interface row_mem_scatter_ctrl_if #(
  parameter int DATA_BW = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATA_BW-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/row_mem_scatter_ctrl.sv
// Scatters a linear element stream into NUM_ROW_MEM row memories using a runtime
// row length, interleave group, pass count and pass step.
module row_mem_scatter_ctrl #(
  parameter int DATA_BW     = 8,
  parameter int ROW_ADDR_W  = 6,
  parameter int NUM_ROW_MEM = 96,
  parameter int ROW_STRIDE  = 32,
  parameter int IDX_W       = $clog2(NUM_ROW_MEM) + 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ROW_ADDR_W:0]       cfg_row_len,
  input  logic [7:0]                cfg_num_rows,
  input  logic [2:0]                cfg_group,
  input  logic [1:0]                cfg_num_pass,
  input  logic [IDX_W-1:0]          cfg_pass_step,
  row_mem_scatter_ctrl_if.slave     stream,
  output logic signed [DATA_BW-1:0] out_data,
  output logic [ROW_ADDR_W-1:0]     out_addr,
  output logic [NUM_ROW_MEM-1:0]    out_en,
  output logic [NUM_ROW_MEM-1:0]    out_we,
  output logic [NUM_ROW_MEM-1:0]    row_active,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int CW = ROW_ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;

  logic [CW-1:0]    row_len_q;
  logic [7:0]       num_rows_q;
  logic [2:0]       group_q;
  logic [1:0]       num_pass_q;
  logic [IDX_W-1:0] step_q;

  logic [CW-1:0] col;
  logic [2:0]    grp;
  logic [7:0]    sub;
  logic [7:0]    row_cnt;
  logic [1:0]    pass;

  logic                   accept;
  logic                   col_last;
  logic                   row_last;
  logic                   job_last;
  logic                   bad_cfg;
  logic                   in_range;
  logic [31:0]            r_full;
  logic [NUM_ROW_MEM-1:0] onehot;

  assign stream.in_ready = (state == LOAD) && !abort;
  assign accept          = stream.in_valid && stream.in_ready;

  assign col_last = (col == row_len_q - CW'(1));
  assign row_last = (row_cnt == num_rows_q - 8'd1);
  assign job_last = col_last && row_last && (pass == num_pass_q);
  assign bad_cfg  = (cfg_row_len == '0) || (cfg_num_rows == 8'd0) || (cfg_group == 3'd0);

  // Row index kept at 32 bits so an out-of-range index is never aliased back into range
  always_comb begin
    r_full   = 32'(pass) * 32'(step_q) + 32'(grp) * 32'(ROW_STRIDE) + 32'(sub);
    in_range = (r_full < 32'(NUM_ROW_MEM));
    onehot   = '0;
    for (int i = 0; i < NUM_ROW_MEM; i++) onehot[i] = (r_full == 32'(i));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      group_q    <= '0;
      num_pass_q <= '0;
      step_q     <= '0;
      col        <= '0;
      grp        <= '0;
      sub        <= '0;
      row_cnt    <= '0;
      pass       <= '0;
      out_data   <= '0;
      out_addr   <= '0;
      out_en     <= '0;
      out_we     <= '0;
      row_active <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      out_en <= '0;
      out_we <= '0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_len_q  <= cfg_row_len;
            num_rows_q <= cfg_num_rows;
            group_q    <= cfg_group;
            num_pass_q <= cfg_num_pass;
            step_q     <= cfg_pass_step;
            col        <= '0;
            grp        <= '0;
            sub        <= '0;
            row_cnt    <= '0;
            pass       <= '0;
            row_active <= '0;
            busy       <= 1'b1;
            if (bad_cfg) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= LOAD;
              err   <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
          end else if (accept) begin
            // Write stage: one-hot strobe lands one cycle after the accepted beat
            out_en     <= onehot;
            out_we     <= onehot;
            out_addr   <= col[ROW_ADDR_W-1:0];
            out_data   <= stream.in_data;
            row_active <= row_active | onehot;
            if (!in_range) err <= 1'b1;
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row_cnt <= '0;
                grp     <= '0;
                sub     <= '0;
                pass    <= pass + 2'd1;
              end else begin
                row_cnt <= row_cnt + 8'd1;
                if (grp == group_q - 3'd1) begin
                  grp <= '0;
                  sub <= sub + 8'd1;
                end else begin
                  grp <= grp + 3'd1;
                end
              end
            end else begin
              col <= col + CW'(1);
            end
            if (job_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_mem_scatter_ctrl.sv
// Bench for row_mem_scatter_ctrl: two instances (96 and 64 row memories) share one stimulus,
// a queue of expected writes is built per job and consumed by a per-cycle write monitor.
module tb_row_mem_scatter_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] cfg_row_len = '0;
  logic [7:0] cfg_num_rows = '0;
  logic [2:0] cfg_group = '0;
  logic [1:0] cfg_num_pass = '0;
  logic [7:0] cfg_pass_step = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic signed [7:0] out_data0, out_data1;
  logic [5:0]        out_addr0, out_addr1;
  logic [95:0]       en0, we0, ra0;
  logic [63:0]       en1, we1, ra1;
  logic              busy0, done0, err0, busy1, done1, err1;

  always #5 clk = ~clk;

  row_mem_scatter_ctrl_if #(.DATA_BW(8)) s0 ();
  row_mem_scatter_ctrl_if #(.DATA_BW(8)) s1 ();
  assign s0.in_valid = in_valid;
  assign s0.in_data  = in_data;
  assign s1.in_valid = in_valid;
  assign s1.in_data  = in_data;

  row_mem_scatter_ctrl #(.NUM_ROW_MEM(96)) dut0 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows), .cfg_group(cfg_group),
    .cfg_num_pass(cfg_num_pass), .cfg_pass_step(cfg_pass_step), .stream(s0),
    .out_data(out_data0), .out_addr(out_addr0), .out_en(en0), .out_we(we0),
    .row_active(ra0), .busy(busy0), .done(done0), .err(err0));

  row_mem_scatter_ctrl #(.NUM_ROW_MEM(64)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows), .cfg_group(cfg_group),
    .cfg_num_pass(cfg_num_pass), .cfg_pass_step(cfg_pass_step[6:0]), .stream(s1),
    .out_data(out_data1), .out_addr(out_addr1), .out_en(en1), .out_we(we1),
    .row_active(ra1), .busy(busy1), .done(done1), .err(err1));

  typedef struct {
    int         row;
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] beat_data[$];
  wr_t        pend;
  bit         pend_v = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         wr0 = 0;
  int         wr1 = 0;
  int         n_beats = 0;
  logic [95:0] exp_ra0;
  logic [63:0] exp_ra1;
  logic        exp_err0, exp_err1;

  // Write monitor: checks the strobe owed by the previous cycle's accept, then looks at this cycle
  always @(negedge clk) begin
    logic [95:0] e0;
    logic [63:0] e1;
    e0 = '0;
    e1 = '0;
    if (pend_v && pend.row < 96) e0[pend.row] = 1'b1;
    if (pend_v && pend.row < 64) e1[pend.row] = 1'b1;
    n_chk++;
    if (en0 !== e0 || we0 !== e0) begin
      n_fail++;
      $display("FAIL wr_strobe96 en=%h we=%h required %h", en0, we0, e0);
    end
    n_chk++;
    if (en1 !== e1 || we1 !== e1) begin
      n_fail++;
      $display("FAIL wr_strobe64 en=%h we=%h required %h", en1, we1, e1);
    end
    if (pend_v && pend.row < 96) begin
      n_chk++;
      if (out_addr0 !== 6'(pend.addr) || out_data0 !== pend.data) begin
        n_fail++;
        $display("FAIL wr_payload96 addr=%0d data=%h required addr=%0d data=%h",
                 out_addr0, out_data0, pend.addr, pend.data);
      end
    end
    if (pend_v && pend.row < 64) begin
      n_chk++;
      if (out_addr1 !== 6'(pend.addr) || out_data1 !== pend.data) begin
        n_fail++;
        $display("FAIL wr_payload64 addr=%0d data=%h required addr=%0d data=%h",
                 out_addr1, out_data1, pend.addr, pend.data);
      end
    end
    if (en0 != '0) wr0++;
    if (en1 != '0) wr1++;
    pend_v = 1'b0;
    if (in_valid === 1'b1 && s0.in_ready === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_accept got accept required none");
      end else begin
        pend   = exp_q.pop_front();
        pend_v = 1'b1;
      end
    end
  end

  task automatic build_job(input int rl, input int nr, input int g, input int np, input int st);
    exp_q.delete();
    beat_data.delete();
    exp_ra0  = '0;
    exp_ra1  = '0;
    exp_err0 = 1'b0;
    exp_err1 = 1'b0;
    for (int p = 0; p <= np; p++)
      for (int k = 0; k < nr; k++) begin
        int r;
        r = p * st + (k % g) * 32 + k / g;
        if (r < 96) exp_ra0[r] = 1'b1; else exp_err0 = 1'b1;
        if (r < 64) exp_ra1[r] = 1'b1; else exp_err1 = 1'b1;
        for (int c = 0; c < rl; c++) begin
          wr_t w;
          w.row  = r;
          w.addr = c;
          w.data = 8'($urandom_range(255));
          exp_q.push_back(w);
          beat_data.push_back(w.data);
        end
      end
    n_beats = beat_data.size();
  endtask

  task automatic kick(input int rl, input int nr, input int g, input int np, input int st);
    @(posedge clk); #1;
    cfg_row_len   = 7'(rl);
    cfg_num_rows  = 8'(nr);
    cfg_group     = 3'(g);
    cfg_num_pass  = 2'(np);
    cfg_pass_step = 8'(st);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds the queued beats; abort_after>=0 cancels the job after that many accepts
  task automatic drive(input int gap_pct, input int abort_after, input bit poke_start);
    int sent  = 0;
    int guard = 0;
    while (sent < n_beats) begin
      @(posedge clk); #1;
      if (abort_after >= 0 && sent == abort_after) begin
        abort    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if (s0.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_ready in_ready=%b required 0", s0.in_ready);
        end
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        return;
      end
      start = poke_start && sent == 10;
      if (start) cfg_row_len = 7'd3;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = beat_data[sent];
      @(negedge clk);
      n_chk++;
      if (done0 !== 1'b0 || busy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_job done=%b busy=%b required done=0 busy=1", done0, busy0);
      end
      if (in_valid && s0.in_ready) sent++;
      guard++;
      if (guard > 5000) begin
        n_fail++;
        $display("FAIL drive_timeout accepted=%0d required %0d", sent, n_beats);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_end(input string name, input int w0, input int w1);
    @(negedge clk);
    n_chk++;
    if (done0 !== 1'b1 || done1 !== 1'b1 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done done0=%b done1=%b busy=%b required 1 1 1", name, done0, done1, busy0);
    end
    @(negedge clk);
    n_chk++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle done=%b busy0=%b busy1=%b required 0 0 0", name, done0, busy0, busy1);
    end
    n_chk++;
    if (ra0 !== exp_ra0 || err0 !== exp_err0) begin
      n_fail++;
      $display("FAIL %s_ra96 ra=%h err=%b required ra=%h err=%b", name, ra0, err0, exp_ra0, exp_err0);
    end
    n_chk++;
    if (ra1 !== exp_ra1 || err1 !== exp_err1) begin
      n_fail++;
      $display("FAIL %s_ra64 ra=%h err=%b required ra=%h err=%b", name, ra1, err1, exp_ra1, exp_err1);
    end
    n_chk++;
    if (wr0 != w0 || wr1 != w1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_writes wr96=%0d wr64=%0d left=%0d required %0d %0d 0",
               name, wr0, wr1, exp_q.size(), w0, w1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (en0 !== '0 || we0 !== '0 || ra0 !== '0 || out_addr0 !== '0 || out_data0 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs en=%h ra=%h addr=%h data=%h required 0", en0, ra0, out_addr0, out_data0);
    end
    n_chk++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || s0.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl busy=%b done=%b err=%b ready=%b required 0", busy0, done0, err0, s0.in_ready);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_linear();
    build_job(5, 5, 1, 0, 0);
    wr0 = 0; wr1 = 0;
    kick(5, 5, 1, 0, 0);
    drive(0, -1, 1'b0);
    check_end("linear", 25, 25);
    n_chk++;
    if (ra0 !== 96'h1F) begin
      n_fail++;
      $display("FAIL linear_mask ra=%h required 1f", ra0);
    end
  endtask

  task automatic test_interleave();
    build_job(4, 6, 3, 0, 0);
    wr0 = 0; wr1 = 0;
    kick(4, 6, 3, 0, 0);
    drive(0, -1, 1'b0);
    check_end("interleave", 24, 16);
    n_chk++;
    if (ra0 !== 96'h3_0000_0003_0000_0003 || ra1 !== 64'h0000_0003_0000_0003 || err1 !== 1'b1 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL interleave_mask ra96=%h ra64=%h err64=%b required 30000000300000003 0000000300000003 1", ra0, ra1, err1);
    end
  endtask

  task automatic test_multipass();
    build_job(2, 3, 1, 2, 3);
    wr0 = 0; wr1 = 0;
    kick(2, 3, 1, 2, 3);
    drive(0, -1, 1'b0);
    check_end("multipass", 18, 18);
    n_chk++;
    if (ra0 !== 96'h1FF || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL multipass_mask ra=%h err=%b required 1ff 0", ra0, err0);
    end
  endtask

  task automatic test_gaps();
    build_job(5, 5, 1, 0, 0);
    wr0 = 0; wr1 = 0;
    kick(5, 5, 1, 0, 0);
    drive(50, -1, 1'b1);
    check_end("gaps", 25, 25);
  endtask

  task automatic test_abort();
    build_job(5, 5, 1, 0, 0);
    kick(5, 5, 1, 0, 0);
    drive(0, 7, 1'b0);
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || en0 !== '0 || s0.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle busy=%b done=%b en=%h ready=%b required 0", busy0, done0, en0, s0.in_ready);
      end
    end
  endtask

  task automatic test_bad_cfg();
    for (int i = 0; i < 3; i++) begin
      exp_q.delete();
      wr0 = 0;
      case (i)
        0:       kick(0, 5, 1, 0, 0);
        1:       kick(4, 0, 1, 0, 0);
        default: kick(4, 5, 0, 0, 0);
      endcase
      @(negedge clk);
      n_chk++;
      if (done0 !== 1'b1 || err0 !== 1'b1 || busy0 !== 1'b1 || en0 !== '0 || ra0 !== '0) begin
        n_fail++;
        $display("FAIL badcfg%0d_done done=%b err=%b busy=%b en=%h ra=%h required 1 1 1 0 0",
                 i, done0, err0, busy0, en0, ra0);
      end
      @(negedge clk);
      n_chk++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || err0 !== 1'b1 || wr0 != 0) begin
        n_fail++;
        $display("FAIL badcfg%0d_idle done=%b busy=%b err=%b writes=%0d required 0 0 1 0",
                 i, done0, busy0, err0, wr0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_interleave();
    test_multipass();
    test_gaps();
    test_abort();
    test_bad_cfg();
    test_linear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
